// File: rtl/crt_47_61_64_to_bin_pkg.sv
// Shared constants for the {47, 61, 64} residue-to-binary converter.
package crt_47_61_64_to_bin_pkg;

    localparam int unsigned MOD_A   = 47;
    localparam int unsigned MOD_B   = 61;
    localparam int unsigned MOD_C   = 64;
    localparam int unsigned M_TOTAL = 183488;

    // Garner constants: inv(47) mod 61 and inv(47*61) mod 64.
    localparam int unsigned INV_A_MOD_B  = 13;
    localparam int unsigned INV_AB_MOD_C = 59;
    localparam int unsigned WEIGHT_AB    = 2867;

    // Multiple of 64 that keeps r64 - v1 - 47*v2 non-negative (>= 46 + 47*60).
    localparam int unsigned V3_BIAS = 45 * MOD_C;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_V2   = 3'd1;
    localparam state_t ST_V3   = 3'd2;
    localparam state_t ST_ACC  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/crt_47_61_64_to_bin_if.sv
// Residue-in / binary-out handshake bundle for the CRT converter.
interface crt_47_61_64_to_bin_if;

    logic        in_valid;
    logic        in_ready;
    logic [5:0]  R47;
    logic [5:0]  R61;
    logic [5:0]  R64;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] X;
    logic        ERR;

    modport master (
        output in_valid, R47, R61, R64, out_ready,
        input  in_ready, out_valid, X, ERR
    );

    modport slave (
        input  in_valid, R47, R61, R64, out_ready,
        output in_ready, out_valid, X, ERR
    );

endinterface

// File: rtl/crt_47_61_64_to_bin_mod61_reduce.sv
// Combinational 13-bit to mod-61 reduction using 2^6 mod 61 = 3.
module mod61_reduce (
    input  logic [12:0] a,
    output logic [5:0]  r
);

    logic [8:0] fold1;
    logic [6:0] fold2;

    // Two folds bring any 13-bit value below 122, so one subtract finishes it.
    always_comb begin
        fold1 = 9'(a[12:6]) * 9'd3 + 9'(a[5:0]);
        fold2 = 7'(fold1[8:6]) * 7'd3 + 7'(fold1[5:0]);
        r     = (fold2 >= 7'd61) ? 6'(fold2 - 7'd61) : fold2[5:0];
    end

endmodule

// File: rtl/crt_47_61_64_to_bin.sv
// Mixed-radix (Garner) conversion of a {47, 61, 64} residue triple to binary.
module crt_47_61_64_to_bin
    import crt_47_61_64_to_bin_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    crt_47_61_64_to_bin_if.slave         bus
);

    state_t      state_q, state_d;
    logic [5:0]  r47_q, r47_d;
    logic [5:0]  r61_q, r61_d;
    logic [5:0]  r64_q, r64_d;
    logic [5:0]  v2_q, v2_d;
    logic [5:0]  v3_q, v3_d;
    logic [17:0] x_q, x_d;
    logic        err_q, err_d;

    logic [12:0] v2_prod;
    logic [5:0]  v2_red;
    logic [5:0]  v3_low;
    logic [5:0]  v3_calc;
    logic [17:0] x_sum;
    logic        err_calc;

    mod61_reduce u_mod61 (
        .a (v2_prod),
        .r (v2_red)
    );

    // Mod-64 steps are plain truncation; the bias only avoids negative values.
    always_comb begin
        v2_prod  = (13'(r61_q) + 13'(MOD_B) - 13'(r47_q)) * 13'(INV_A_MOD_B);
        v3_low   = 6'(12'(r64_q) + 12'(V3_BIAS) - 12'(r47_q) - 12'(v2_q) * 12'(MOD_A));
        v3_calc  = 6'(v3_low * 6'(INV_AB_MOD_C));
        x_sum    = 18'(r47_q) + 18'(v2_q) * 18'(MOD_A) + 18'(v3_q) * 18'(WEIGHT_AB);
        err_calc = (r47_q > 6'(MOD_A - 1)) || (r61_q > 6'(MOD_B - 1));
    end

    always_comb begin
        state_d = state_q;
        r47_d   = r47_q;
        r61_d   = r61_q;
        r64_d   = r64_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        x_d     = x_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    r47_d   = bus.R47;
                    r61_d   = bus.R61;
                    r64_d   = bus.R64;
                    state_d = ST_V2;
                end
            end
            ST_V2: begin
                v2_d    = v2_red;
                state_d = ST_V3;
            end
            ST_V3: begin
                v3_d    = v3_calc;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                err_d   = err_calc;
                x_d     = err_calc ? '0 : x_sum;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r47_q   <= '0;
            r61_q   <= '0;
            r64_q   <= '0;
            v2_q    <= '0;
            v3_q    <= '0;
            x_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r47_q   <= r47_d;
            r61_q   <= r61_d;
            r64_q   <= r64_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            x_q     <= x_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.X         = x_q;
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_crt_47_61_64_to_bin.sv
// Scoreboard bench for crt_47_61_64_to_bin against a search-based CRT model.
module tb_crt_47_61_64_to_bin;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    logic b2b;
    logic have_prev;
    int   prev_acc;
    logic seen;
    logic [17:0] hold_x;
    logic        hold_err;

    logic [18:0] sb_q[$];
    int          acc_q[$];

    crt_47_61_64_to_bin_if bus ();

    crt_47_61_64_to_bin dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The unique x < 183488 with the given residues, found by searching x = r64 + 64k.
    function automatic logic [18:0] ref_crt(input int a, input int b, input int c);
        if (a > 46 || b > 60) return {1'b1, 18'd0};
        for (int k = 0; k < 2867; k++) begin
            int x;
            x = c + 64 * k;
            if (x % 47 == a && x % 61 == b) return {1'b0, 18'(x)};
        end
        return '1;
    endfunction

    task automatic send(input int a, input int b, input int c);
        int waited;
        bus.R47      = 6'(a);
        bus.R61      = 6'(b);
        bus.R64      = 6'(c);
        bus.in_valid = 1'b1;
        sb_q.push_back(ref_crt(a, b, c));
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    // Monitor: records accepts, pops the scoreboard on each new result, checks holds.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                if (b2b && have_prev) check("accept_gap", cyc + 1 - prev_acc, 5);
                prev_acc  = cyc + 1;
                have_prev = 1'b1;
                acc_q.push_back(cyc + 1);
            end
            if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb_q.size() == 0 || acc_q.size() == 0) begin
                        check("unexpected_out_valid", 1, 0);
                    end else begin
                        logic [18:0] e;
                        int a_cyc;
                        e     = sb_q.pop_front();
                        a_cyc = acc_q.pop_front();
                        check("result_x", int'(bus.X), int'(e[17:0]));
                        check("result_err", int'(bus.ERR), int'(e[18]));
                        check("latency", cyc - a_cyc + 1, 4);
                    end
                    hold_x   = bus.X;
                    hold_err = bus.ERR;
                end else begin
                    check("hold_x", int'(bus.X), int'(hold_x));
                    check("hold_err", int'(bus.ERR), int'(hold_err));
                end
                check("in_ready_in_done", int'(bus.in_ready), 0);
                if (bus.out_ready) seen = 1'b0;
            end
        end
    end

    initial begin
        total        = 0;
        bad          = 0;
        b2b          = 1'b0;
        have_prev    = 1'b0;
        prev_acc     = 0;
        seen         = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.R47      = '0;
        bus.R61      = '0;
        bus.R64      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_x", int'(bus.X), 0);
        check("rst_err", int'(bus.ERR), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, 0, 0);     idle(); drain();
        send(31, 21, 32);  idle(); drain();
        send(46, 60, 63);  idle(); drain();
        send(47, 5, 5);    idle(); drain();
        send(5, 61, 0);    idle(); drain();
        send(63, 63, 63);  idle(); drain();

        // Stalled consumer: result must sit unchanged.
        bus.out_ready = 1'b0;
        send(0, 47, 47);
        idle();
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        check("stall_out_valid", int'(bus.out_valid), 1);
        repeat (10) @(negedge clk);
        check("stall_still_valid", int'(bus.out_valid), 1);
        check("stall_x", int'(bus.X), 47);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // Reset while in V3 aborts the conversion.
        send(31, 21, 32);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        acc_q.delete();
        #1;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_pulse", int'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(31, 21, 32);  idle(); drain();

        // Back-to-back with in_valid held high and consumer always ready.
        have_prev = 1'b0;
        b2b       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int x;
            x = int'($urandom_range(183487, 0));
            send(x % 47, x % 61, x % 64);
        end
        idle();
        drain();
        b2b = 1'b0;

        // Random sweep including some out-of-range residues.
        for (int i = 0; i < 25; i++) begin
            int x;
            x = int'($urandom_range(183487, 0));
            if (i % 5 == 4) send(int'($urandom_range(63, 0)), int'($urandom_range(63, 0)), x % 64);
            else            send(x % 47, x % 61, x % 64);
            idle();
            repeat (int'($urandom_range(2, 0))) @(posedge clk);
            #1;
        end
        drain();
        check("acc_queue_empty", acc_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t required=<2000000", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/crt_47_61_64_to_bin.md
CRT_47_61_64_TO_BIN -- requirements
Module: crt_47_61_64_to_bin

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  input  1  residue triple present.
REQ-004 SHALL have: in_ready  output  1  block can accept a triple.
REQ-005 SHALL have: R47  input  6  residue mod 47, legal 0..46.
REQ-006 SHALL have: R61  input  6  residue mod 61, legal 0..60.
REQ-007 SHALL have: R64  input  6  residue mod 64, legal 0..63.
REQ-008 SHALL have: out_valid  output  1  result held.
REQ-009 SHALL have: out_ready  input  1  consumer takes result.
REQ-010 SHALL have: X  output  18  reconstructed binary value, 0..183487.
REQ-011 SHALL have: ERR  output  1  input triple had an out-of-range residue.
REQ-012 SHALL have no parameters; moduli set {47, 61, 64}, M = 183488, fixed.

Function
REQ-013 SHALL reconstruct X by mixed-radix (Garner) conversion: v1 = R47; v2 = ((R61 - v1) * 13) mod 61; v3 = ((R64 - v1 - 47*v2) * 59) mod 64; X = v1 + 47*v2 + 2867*v3.
REQ-014 SHALL use constants inv(47) mod 61 = 13 and inv(2867) mod 64 = 59.
REQ-015 SHALL form modular subtractions without negative intermediates, adding a multiple of the modulus before reduction.
REQ-016 SHALL implement FSM states IDLE, V2, V3, ACC, DONE.
REQ-017 IDLE: in_ready = 1; on in_valid && in_ready latch R47/R61/R64, go to V2.
REQ-018 V2: compute and register v2, go to V3; V3: register v3, go to ACC; ACC: register X and ERR, go to DONE.
REQ-019 DONE: out_valid = 1; X and ERR stable; on out_ready go to IDLE.
REQ-020 Latency SHALL be exactly 4 cycles from accept edge to out_valid high; throughput one triple per 5 cycles minimum.
REQ-021 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE is ignored.
REQ-022 out_valid SHALL be 1 only in DONE; out_ready outside DONE is ignored.
REQ-023 ERR SHALL be 1 when latched R47 > 46 or R61 > 60; then X SHALL be 0; the FSM sequence and latency are unchanged.
REQ-024 Held DONE with out_ready = 0 SHALL persist indefinitely without change.
REQ-025 In the cycle out_ready is sampled in DONE, in_ready SHALL still be 0; the next triple is accepted no earlier than the following cycle.
REQ-026 The result SHALL always be < 183488 for legal inputs; no final correction subtraction is needed beyond the mod reductions of REQ-013.

Reset
REQ-027 On rst_n = 0, asynchronously: state = IDLE, in_ready = 1, out_valid = 0, X = 0, ERR = 0, internal registers = 0.
REQ-028 Reset mid-conversion SHALL abort the conversion with no output pulse; after release, operation restarts from IDLE.

Structure
REQ-029 Moduli (47, 61, 64), inverses (13, 59), the weight 2867, and the FSM state enumeration SHALL reside in the shared modulus package.
REQ-030 A single combinational sub-module mod61_reduce (13-bit input to 6-bit residue, folding by 2^6 mod 61 = 3, then one conditional subtract) SHALL be instantiated for v2; mod 64 is bit truncation.

Verification
REQ-031 R = (0,0,0) -> after 4 cycles out_valid = 1, X = 0, ERR = 0.
REQ-032 R = (31,21,32) -> X = 100000, ERR = 0; R = (46,60,63) -> X = 183487.
REQ-033 R = (0,47,47) -> X = 47; hold out_ready = 0 for 10 cycles -> X and out_valid stable, in_ready = 0.
REQ-034 R = (47,5,5) -> ERR = 1, X = 0, latency still 4 cycles.
REQ-035 Assert rst_n low in the V3 state -> out_valid never rises, in_ready = 1 immediately; the next triple (31,21,32) yields 100000.
REQ-036 Back-to-back in_valid with out_ready tied 1 -> one accept per 5 cycles; random legal X sweep matches X = CRT(X mod 47, X mod 61, X mod 64).
